neuron_update_engine: RTL and testbench

Time-multiplexed integrate-and-fire stage for a core of NUM_NEURONS neurons. It sits directly upstream and downstream of the leak multiplier. The block stores per-neuron membrane potentials and synaptic accumulators, and on each tick streams every potential out to the leak multiplier. It then takes back the leaked value, adds accumulated synaptic input, compares against threshold, resets fired neurons and emits spike events over a valid/ready handshake.

---
 rtl/neuron_update_engine.sv | 108 ++++++++++
 tb/tb_neuron_update_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_update_engine.sv
// rtl/neuron_update_engine.sv - time-multiplexed integrate-and-fire update stage
module neuron_update_engine #(
  parameter int          NUM_NEURONS = 16,
  parameter int          ID_W        = 4,
  parameter logic [7:0]  RESET_VAL   = 8'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_start,
  input  logic [7:0]      threshold,
  input  logic [7:0]      leak_weight_cfg,
  input  logic            syn_valid,
  output logic            syn_ready,
  input  logic [ID_W-1:0] syn_id,
  input  logic [7:0]      syn_weight,
  output logic [7:0]      leak_pot_out,
  output logic [7:0]      leak_wt_out,
  input  logic [7:0]      leak_in,
  output logic            spike_valid,
  input  logic            spike_ready,
  output logic [ID_W-1:0] spike_id,
  output logic            busy,
  output logic            tick_done
);

  typedef enum logic [2:0] {IDLE, LEAK, INTEG, FIRE, DONE} state_t;

  localparam logic [ID_W:0]   NUM_W    = (ID_W+1)'(NUM_NEURONS);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] idx;
  logic [7:0]      leaked;
  logic [7:0]      pot [NUM_NEURONS];
  logic [7:0]      acc [NUM_NEURONS];

  logic       syn_fire;
  logic       syn_in_range;
  logic [8:0] syn_sum;
  logic [7:0] syn_sat;
  logic [8:0] integ_sum;
  logic [7:0] integ_sat;
  logic       fire;
  logic       last;

  assign syn_fire     = syn_valid && syn_ready;
  assign syn_in_range = ({1'b0, syn_id} < NUM_W);
  assign syn_sum      = {1'b0, acc[syn_id]} + {1'b0, syn_weight};
  assign syn_sat      = syn_sum[8] ? 8'hFF : syn_sum[7:0];
  assign integ_sum    = {1'b0, leaked} + {1'b0, acc[idx]};
  assign integ_sat    = integ_sum[8] ? 8'hFF : integ_sum[7:0];
  assign fire         = (integ_sat >= threshold);
  assign last         = (idx == LAST_IDX);

  assign syn_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign tick_done    = (state == DONE);
  assign spike_valid  = (state == FIRE);
  assign spike_id     = (state == FIRE) ? idx : '0;
  assign leak_pot_out = pot[idx];
  assign leak_wt_out  = leak_weight_cfg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick_start) state_nxt = LEAK;
      LEAK:    state_nxt = INTEG;
      INTEG: begin
        if (fire)      state_nxt = FIRE;
        else if (last) state_nxt = DONE;
        else           state_nxt = LEAK;
      end
      FIRE:    if (spike_ready) state_nxt = last ? DONE : LEAK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      leaked <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // out-of-range targets are accepted but dropped
          if (syn_fire && syn_in_range) acc[syn_id] <= syn_sat;
          if (tick_start) idx <= '0;
        end
        LEAK: leaked <= leak_in;
        INTEG: begin
          acc[idx] <= '0;
          pot[idx] <= fire ? RESET_VAL : integ_sat;
          if (!fire && !last) idx <= idx + 1'b1;
        end
        FIRE: if (spike_ready && !last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_update_engine.sv
// tb/tb_neuron_update_engine.sv - scoreboard bench for neuron_update_engine
module tb_neuron_update_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_start = 1'b0;
  logic [7:0] threshold = 8'd200;
  logic [7:0] leak_weight_cfg = 8'd255;
  logic       syn_valid = 1'b0;
  logic       syn_ready;
  logic [3:0] syn_id = 4'd0;
  logic [7:0] syn_weight = 8'd0;
  logic [7:0] leak_pot_out;
  logic [7:0] leak_wt_out;
  logic [7:0] leak_in;
  logic       spike_valid;
  logic       spike_ready = 1'b1;
  logic [3:0] spike_id;
  logic       busy;
  logic       tick_done;

  logic [15:0] leak_prod;
  assign leak_prod = leak_pot_out * leak_wt_out;
  assign leak_in   = leak_prod[15:8];

  neuron_update_engine #(.NUM_NEURONS(16), .ID_W(4), .RESET_VAL(8'd0)) dut (
    .clk(clk), .rst(rst), .tick_start(tick_start), .threshold(threshold),
    .leak_weight_cfg(leak_weight_cfg), .syn_valid(syn_valid), .syn_ready(syn_ready),
    .syn_id(syn_id), .syn_weight(syn_weight), .leak_pot_out(leak_pot_out),
    .leak_wt_out(leak_wt_out), .leak_in(leak_in), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_id(spike_id), .busy(busy), .tick_done(tick_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int spike_q[$];
  int done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT completes a spike or ends a pass
  always @(negedge clk) begin
    if (!rst && spike_valid && spike_ready) begin
      if (spike_q.size() == 0) check("unexpected_spike", int'(spike_id), -1);
      else check("spike_id", int'(spike_id), spike_q.pop_front());
    end
    if (!rst && tick_done) begin
      if (done_q.size() == 0) check("unexpected_tick_done", cyc, -1);
      else check("tick_done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic send_event(input int id, input int w);
    syn_valid  = 1'b1;
    syn_id     = 4'(id);
    syn_weight = 8'(w);
    @(posedge clk); #1;
    syn_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_end);
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle_cycle"}, cyc, exp_end);
  endtask

  task automatic run_tick(input string name, input int lat);
    int t0;
    tick_start = 1'b1;
    t0 = cyc;
    done_q.push_back(t0 + lat);
    @(posedge clk); #1;
    tick_start = 1'b0;
    wait_idle(name, t0 + lat + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    int nz;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_syn_ready", int'(syn_ready), 1);
    check("rst_spike_valid", int'(spike_valid), 0);
    check("rst_spike_id", int'(spike_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tick_done", int'(tick_done), 0);
    check("rst_leak_pot_out", int'(leak_pot_out), 0);

    // 1: accumulate to 100, no spike
    send_event(3, 50);
    send_event(3, 50);
    tick_start = 1'b1;
    t0 = cyc;
    done_q.push_back(t0 + 33);
    @(posedge clk); #1;
    tick_start = 1'b0;
    check("t1_busy_first", int'(busy), 1);
    check("t1_leak_wt_out", int'(leak_wt_out), 255);
    wait_idle("t1", t0 + 34);
    check("t1_pot3", int'(dut.pot[3]), 100);

    // 2: 99 + 150 = 249 fires
    send_event(3, 150);
    spike_q.push_back(3);
    run_tick("t2", 34);
    check("t2_pot3", int'(dut.pot[3]), 0);

    // 3: saturating accumulator, threshold 255
    send_event(5, 200);
    send_event(5, 200);
    check("t3_acc5_sat", int'(dut.acc[5]), 255);
    threshold = 8'd255;
    spike_q.push_back(5);
    run_tick("t3", 34);
    check("t3_acc5_clr", int'(dut.acc[5]), 0);
    threshold = 8'd200;

    // 4: backpressure on spike for neuron 2
    send_event(2, 250);
    spike_ready = 1'b0;
    tick_start = 1'b1;
    t0 = cyc;
    spike_q.push_back(2);
    done_q.push_back(t0 + 39);
    @(posedge clk); #1;
    tick_start = 1'b0;
    n = 0;
    while (!spike_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_spike_rise_cycle", cyc, t0 + 7);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", int'(spike_valid), 1);
      check("t4_hold_id", int'(spike_id), 2);
      syn_valid  = 1'b1;
      syn_id     = 4'd0;
      syn_weight = 8'd10;
      tick_start = (k % 2 == 1);
      check("t4_syn_ready_busy", int'(syn_ready), 0);
      @(posedge clk); #1;
    end
    syn_valid   = 1'b0;
    tick_start  = 1'b0;
    spike_ready = 1'b1;
    check("t4_hold_valid_last", int'(spike_valid), 1);
    check("t4_hold_id_last", int'(spike_id), 2);
    @(posedge clk); #1;
    wait_idle("t4", t0 + 40);
    check("t4_acc0_unchanged", int'(dut.acc[0]), 0);
    repeat (3) @(posedge clk);
    #1 check("t4_no_second_pass", int'(busy), 0);

    // 5: zero leak weight empties the potential; threshold 0 fires all
    send_event(7, 100);
    run_tick("t5a", 33);
    check("t5_pot7_loaded", int'(dut.pot[7]), 100);
    leak_weight_cfg = 8'd0;
    run_tick("t5b", 33);
    check("t5_pot7_leaked", int'(dut.pot[7]), 0);
    leak_weight_cfg = 8'd255;
    threshold = 8'd0;
    for (int i = 0; i < 16; i++) spike_q.push_back(i);
    run_tick("t5c", 49);
    threshold = 8'd200;

    // 6: reset during LEAK of neuron 8 with neuron 10 about to fire
    send_event(3, 40);
    send_event(10, 250);
    tick_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    tick_start = 1'b0;
    while (cyc < t0 + 17) begin
      @(posedge clk); #1;
    end
    check("t6_leak_idx8", int'(dut.idx), 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_busy", int'(busy), 0);
    check("t6_spike_valid", int'(spike_valid), 0);
    check("t6_syn_ready", int'(syn_ready), 1);
    check("t6_tick_done", int'(tick_done), 0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.pot[i] != 0 || dut.acc[i] != 0) nz++;
    check("t6_storage_cleared", nz, 0);
    repeat (60) @(posedge clk);
    #1;

    check("end_spike_q_empty", spike_q.size(), 0);
    check("end_done_q_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
